// File: rtl/tx_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package tx_arb_pkg;

  localparam int TX_ARB_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    RELEASE = 2'd2
  } tx_arb_state_t;

endpackage

// File: rtl/tx_arbiter_rr_pick.sv
// Combinational round-robin search: first asserted request after last_idx, wrapping.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_idx,
  output logic               found,
  output logic [IDX_W-1:0]   next_idx
);

  logic [IDX_W-1:0]   cand_idx [NUM_REQ];
  logic [NUM_REQ-1:0] cand_hit;

  // Candidate gi is the requester gi+1 positions after the last grant.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
    assign cand_idx[gi] = IDX_W'((int'(last_idx) + gi + 1) % NUM_REQ);
    assign cand_hit[gi] = req[cand_idx[gi]];
  end

  assign found = |cand_hit;

  always_comb begin
    next_idx = last_idx;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (cand_hit[k]) next_idx = cand_idx[k];
    end
  end

endmodule

// File: rtl/tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte producers.
// Optional send watchdog enabled by defining TX_ARB_TIMEOUT_EN.
module tx_arbiter
  import tx_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int DATA_W         = TX_ARB_DATA_W,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         ack,
  output logic                       tx_send,
  output logic [DATA_W-1:0]          tx_din,
  input  logic                       tx_sent,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       timeout_err
);

  localparam int IDX_W = $clog2(NUM_REQ);

  tx_arb_state_t      state_q, state_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic               tx_send_q, tx_send_d;
  logic [DATA_W-1:0]  tx_din_q, tx_din_d;
  logic [IDX_W-1:0]   grant_q, grant_d;

  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic               grant_fire;
  logic               wd_expire;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req      (req),
    .last_idx (grant_q),
    .found    (pick_found),
    .next_idx (pick_idx)
  );

  assign grant_fire = (state_q == IDLE) && pick_found;

`ifdef TX_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
  logic             timeout_q;

  // A real tx_sent in the expiry cycle takes precedence over the abort.
  assign wd_expire = (state_q == SEND) && !tx_sent &&
                     (wd_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    wd_cnt_d = wd_cnt_q;
    if (grant_fire)            wd_cnt_d = '0;
    else if (state_q == SEND)  wd_cnt_d = wd_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_cnt_q  <= wd_cnt_d;
      timeout_q <= wd_expire;
    end
  end

  assign timeout_err = timeout_q;
`else
  assign wd_expire   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (pick_found)            state_d = SEND;
      SEND:    if (tx_sent || wd_expire)  state_d = RELEASE;
      RELEASE: if (!tx_sent)              state_d = IDLE;
      default:                            state_d = IDLE;
    endcase
  end

  // Output logic; ack, tx_din, grant_id and tx_send are registered below.
  always_comb begin
    ack_d     = '0;
    tx_din_d  = tx_din_q;
    grant_d   = grant_q;
    tx_send_d = (state_q == SEND) && !tx_sent && !wd_expire;
    if (grant_fire) begin
      ack_d    = NUM_REQ'(1) << pick_idx;
      tx_din_d = req_data[pick_idx*DATA_W +: DATA_W];
      grant_d  = pick_idx;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ack_q     <= '0;
      tx_send_q <= 1'b0;
      tx_din_q  <= '0;
      grant_q   <= IDX_W'(NUM_REQ - 1);
    end else begin
      ack_q     <= ack_d;
      tx_send_q <= tx_send_d;
      tx_din_q  <= tx_din_d;
      grant_q   <= grant_d;
    end
  end

  assign ack      = ack_q;
  assign tx_send  = tx_send_q;
  assign tx_din   = tx_din_q;
  assign grant_id = grant_q;
  assign busy     = (state_q != IDLE);

endmodule
